// File: rtl/prf_debug_sequencer.sv
// prf_debug_sequencer: serialises host word reads/writes into byte accesses on the PRF debug port
//   Optional feature macro PRF_INIT_CLEAR_EN: after reset, zero-fill every PRF byte before accepting requests.
//   Ports: clk, reset (async, active-low); req_valid_i/req_ready_o/req_we_i/req_addr_i/req_wdata_i host request;
//   abort_i cancels an in-flight transfer; resp_valid_o/resp_rdata_o completion pulse and read word;
//   debugPRFAddr_o/debugPRFWrData_o/debugPRFWrEn_o/debugPRFRdData_i byte-wide PRF port; busy_o high when not idle.
module prf_debug_sequencer #(
  parameter int PHYS_LOG = 7,
  parameter int BYTE_OFF = 3,
  parameter int SRAM_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid_i,
  output logic req_ready_o,
  input  logic req_we_i,
  input  logic [PHYS_LOG-1:0] req_addr_i,
  input  logic [(SRAM_W<<BYTE_OFF)-1:0] req_wdata_i,
  input  logic abort_i,
  output logic resp_valid_o,
  output logic [(SRAM_W<<BYTE_OFF)-1:0] resp_rdata_o,
  output logic [PHYS_LOG+BYTE_OFF-1:0] debugPRFAddr_o,
  output logic [SRAM_W-1:0] debugPRFWrData_o,
  output logic debugPRFWrEn_o,
  input  logic [SRAM_W-1:0] debugPRFRdData_i,
  output logic busy_o
);
`ifdef PRF_INIT_CLEAR_EN
  typedef enum logic [1:0] {IDLE, XFER, DRAIN, CLEAR} state_t;
  localparam state_t RESET_STATE = CLEAR;
`else
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif
  state_t state;
  logic [BYTE_OFF-1:0] cnt, nextCnt, prevCnt;
  logic isWe;
  logic [PHYS_LOG-1:0] regAddr;
  logic [(SRAM_W<<BYTE_OFF)-1:0] wdata;
  assign nextCnt = cnt + 1'b1;
  // read data lags its address by one cycle, so the byte captured at each edge is the previous index
  assign prevCnt = cnt - 1'b1;
  assign busy_o = state != IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RESET_STATE;
      cnt <= '0;
      isWe <= 1'b0;
      regAddr <= '0;
      wdata <= '0;
      req_ready_o <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      debugPRFAddr_o <= '0;
      debugPRFWrData_o <= '0;
      debugPRFWrEn_o <= 1'b0;
    end else begin
      resp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            state <= XFER;
            cnt <= '0;
            isWe <= req_we_i;
            regAddr <= req_addr_i;
            wdata <= req_wdata_i;
            req_ready_o <= 1'b0;
            debugPRFAddr_o <= {req_addr_i, {BYTE_OFF{1'b0}}};
            debugPRFWrEn_o <= req_we_i;
            debugPRFWrData_o <= req_we_i ? req_wdata_i[SRAM_W-1:0] : '0;
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        XFER: begin
          if (abort_i) begin
            state <= IDLE;
            cnt <= '0;
            req_ready_o <= 1'b1;
            debugPRFAddr_o <= '0;
            debugPRFWrData_o <= '0;
            debugPRFWrEn_o <= 1'b0;
          end else begin
            if (!isWe && cnt != '0) resp_rdata_o[SRAM_W*prevCnt +: SRAM_W] <= debugPRFRdData_i;
            if (&cnt) begin
              state <= isWe ? IDLE : DRAIN;
              cnt <= '0;
              resp_valid_o <= isWe;
              req_ready_o <= isWe;
              debugPRFAddr_o <= '0;
              debugPRFWrData_o <= '0;
              debugPRFWrEn_o <= 1'b0;
            end else begin
              cnt <= nextCnt;
              debugPRFAddr_o <= {regAddr, nextCnt};
              debugPRFWrData_o <= isWe ? wdata[SRAM_W*nextCnt +: SRAM_W] : '0;
            end
          end
        end
        DRAIN: begin
          // cnt is back at 0 here, so prevCnt selects the last byte
          if (!abort_i) begin
            resp_rdata_o[SRAM_W*prevCnt +: SRAM_W] <= debugPRFRdData_i;
            resp_valid_o <= 1'b1;
          end
          state <= IDLE;
          req_ready_o <= 1'b1;
        end
`ifdef PRF_INIT_CLEAR_EN
        CLEAR: begin
          // the address register doubles as the fill counter; the first edge only raises the strobe
          if (!debugPRFWrEn_o) begin
            debugPRFWrEn_o <= 1'b1;
            debugPRFAddr_o <= '0;
          end else if (&debugPRFAddr_o) begin
            state <= IDLE;
            req_ready_o <= 1'b1;
            debugPRFWrEn_o <= 1'b0;
            debugPRFAddr_o <= '0;
          end else begin
            debugPRFAddr_o <= debugPRFAddr_o + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prf_debug_sequencer.sv
// tb_prf_debug_sequencer: randomized self-checking bench with a byte-array PRF model and word-level reference
module tb_prf_debug_sequencer;
  localparam int PL = 7, BO = 3, SW = 8, NB = 1 << BO, WW = SW * NB, AW = PL + BO;
`ifdef PRF_INIT_CLEAR_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif
  logic clk = 0, reset = 1, req_valid_i = 0, req_we_i = 0, abort_i = 0;
  logic [PL-1:0] req_addr_i = '0;
  logic [WW-1:0] req_wdata_i = '0;
  logic req_ready_o, resp_valid_o, debugPRFWrEn_o, busy_o;
  logic [WW-1:0] resp_rdata_o;
  logic [AW-1:0] debugPRFAddr_o;
  logic [SW-1:0] debugPRFWrData_o;
  logic [SW-1:0] debugPRFRdData_i = '0;
  int checks = 0, fails = 0, respCount = 0;
  logic [SW-1:0] mem [0:(1<<AW)-1];
  logic [AW+SW-1:0] strobes [$];
  logic [WW-1:0] expRdata = '0;

  prf_debug_sequencer #(.PHYS_LOG(PL), .BYTE_OFF(BO), .SRAM_W(SW)) dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .abort_i(abort_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .debugPRFAddr_o(debugPRFAddr_o),
    .debugPRFWrData_o(debugPRFWrData_o), .debugPRFWrEn_o(debugPRFWrEn_o),
    .debugPRFRdData_i(debugPRFRdData_i), .busy_o(busy_o));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (debugPRFWrEn_o) mem[debugPRFAddr_o] <= debugPRFWrData_o;
    debugPRFRdData_i <= mem[debugPRFAddr_o];
  end

  always @(negedge clk) begin
    if (debugPRFWrEn_o) strobes.push_back({debugPRFAddr_o, debugPRFWrData_o});
    if (resp_valid_o) respCount++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  function automatic logic [WW-1:0] model_read(input logic [PL-1:0] a);
    logic [WW-1:0] w;
    for (int k = 0; k < NB; k++) w[k*SW +: SW] = mem[{a, BO'(k)}];
    return w;
  endfunction

  task automatic run_req(input logic we, input logic [PL-1:0] a, input logic [WW-1:0] d, output int lat);
    int n = 0;
    strobes.delete();
    req_valid_i = 1; req_we_i = we; req_addr_i = a; req_wdata_i = d;
    while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid_i = 0;
    lat = 1;
    while (!resp_valid_o && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset();
    #1 reset = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready_o, resp_valid_o, debugPRFWrEn_o, debugPRFAddr_o, debugPRFWrData_o, resp_rdata_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b resp=%b wren=%b addr=%h wdata=%h rdata=%h, required all 0",
               req_ready_o, resp_valid_o, debugPRFWrEn_o, debugPRFAddr_o, debugPRFWrData_o, resp_rdata_o);
    end
    checks++;
    if (busy_o !== BUSY_RST) begin fails++; $display("FAIL reset_busy: got %b required %b", busy_o, BUSY_RST); end
    strobes.delete();
    reset = 1;
`ifdef PRF_INIT_CLEAR_EN
    begin
      int n = 0;
      bool_loop: while (!req_ready_o && n < 1200) begin @(negedge clk); n++; end
      checks++;
      if (strobes.size() != (1 << AW)) begin fails++; $display("FAIL clear_count: got %0d required %0d", strobes.size(), 1 << AW); end
      n = 0;
      for (int i = 0; i < strobes.size(); i++) if (strobes[i] !== {AW'(i), SW'(0)}) n++;
      checks++;
      if (n != 0) begin fails++; $display("FAIL clear_content: %0d bad strobes, required 0", n); end
      checks++;
      if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin fails++; $display("FAIL clear_done: ready=%b busy=%b required 1 0", req_ready_o, busy_o); end
    end
`else
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin fails++; $display("FAIL first_ready: ready=%b busy=%b required 1 0", req_ready_o, busy_o); end
`endif
  endtask

  task automatic test_write_basic();
    int lat, bad = 0;
    logic [WW-1:0] d = 64'h0807060504030201;
    run_req(1'b1, 7'd5, d, lat);
    checks++;
    if (lat != 9) begin fails++; $display("FAIL write_latency: got %0d required 9", lat); end
    checks++;
    if (strobes.size() != 8) begin fails++; $display("FAIL write_strobe_count: got %0d required 8", strobes.size()); end
    for (int k = 0; k < NB && k < strobes.size(); k++) if (strobes[k] !== {AW'(8'h28 + k), SW'(k + 1)}) bad++;
    checks++;
    if (bad != 0) begin fails++; $display("FAIL write_strobes: %0d wrong addr/data, required 0", bad); end
    checks++;
    if (resp_rdata_o !== expRdata) begin fails++; $display("FAIL write_rdata_kept: got %h required %h", resp_rdata_o, expRdata); end
    @(negedge clk);
    checks++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin fails++; $display("FAIL write_pulse: resp=%b ready=%b required 0 1", resp_valid_o, req_ready_o); end
  endtask

  task automatic test_read_basic();
    int lat;
    for (int k = 0; k < NB; k++) mem[8'h28 + k] = SW'(8'h11 * (k + 1));
    run_req(1'b0, 7'd5, '0, lat);
    checks++;
    if (lat != 10) begin fails++; $display("FAIL read_latency: got %0d required 10", lat); end
    checks++;
    if (resp_rdata_o !== 64'h8877665544332211) begin fails++; $display("FAIL read_data: got %h required 8877665544332211", resp_rdata_o); end
    checks++;
    if (strobes.size() != 0) begin fails++; $display("FAIL read_no_strobes: got %0d required 0", strobes.size()); end
    expRdata = 64'h8877665544332211;
    repeat (3) @(negedge clk);
    checks++;
    if (resp_rdata_o !== expRdata) begin fails++; $display("FAIL read_hold: got %h required %h", resp_rdata_o, expRdata); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      logic we = 1'($urandom);
      logic [PL-1:0] a = PL'($urandom);
      logic [WW-1:0] d = {$urandom, $urandom};
      logic [WW-1:0] exp = model_read(a);
      int lat, bad = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_req(we, a, d, lat);
      checks++;
      if (lat != (we ? 9 : 10)) begin fails++; $display("FAIL rand_latency[%0d]: got %0d required %0d", t, lat, we ? 9 : 10); end
      if (we) begin
        if (strobes.size() != NB) bad++;
        for (int k = 0; k < NB && k < strobes.size(); k++) if (strobes[k] !== {a, BO'(k), d[k*SW +: SW]}) bad++;
        for (int k = 0; k < NB; k++) if (mem[{a, BO'(k)}] !== d[k*SW +: SW]) bad++;
        checks++;
        if (bad != 0) begin fails++; $display("FAIL rand_write[%0d]: %0d wrong strobes/bytes, required 0", t, bad); end
      end else begin
        expRdata = exp;
      end
      checks++;
      if (resp_rdata_o !== expRdata) begin fails++; $display("FAIL rand_rdata[%0d]: got %h required %h", t, resp_rdata_o, expRdata); end
    end
  endtask

  task automatic test_abort();
    logic [PL-1:0] a = PL'($urandom);
    logic [WW-1:0] d = {$urandom, $urandom};
    logic [WW-1:0] old = ~d;
    int n = 0, r0, bad = 0;
    for (int k = 0; k < NB; k++) mem[{a, BO'(k)}] = old[k*SW +: SW];
    @(negedge clk);
    strobes.delete();
    r0 = respCount;
    req_valid_i = 1; req_we_i = 1; req_addr_i = a; req_wdata_i = d;
    while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid_i = 0;
    n = 0;
    while (!(debugPRFWrEn_o && debugPRFAddr_o[BO-1:0] == 3) && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin fails++; $display("FAIL abort_reach_byte3: not seen within 20 cycles, required seen"); end
    abort_i = 1;
    @(negedge clk);
    abort_i = 0;
    checks++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || debugPRFWrEn_o !== 1'b0) begin
      fails++; $display("FAIL abort_idle: ready=%b busy=%b wren=%b required 1 0 0", req_ready_o, busy_o, debugPRFWrEn_o);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (respCount != r0) begin fails++; $display("FAIL abort_no_resp: got %0d pulses required 0", respCount - r0); end
    checks++;
    if (strobes.size() != 4) begin fails++; $display("FAIL abort_strobe_count: got %0d required 4", strobes.size()); end
    for (int k = 0; k < NB; k++) if (mem[{a, BO'(k)}] !== (k < 4 ? d[k*SW +: SW] : old[k*SW +: SW])) bad++;
    checks++;
    if (bad != 0) begin fails++; $display("FAIL abort_bytes: %0d wrong bytes, required 0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [PL-1:0] a1 = PL'($urandom);
    logic [PL-1:0] a2 = a1 + 1'b1;
    logic [WW-1:0] d1 = {$urandom, $urandom}, d2 = {$urandom, $urandom};
    int n = 0, bad = 0, lat = 0;
    @(negedge clk);
    req_valid_i = 1; req_we_i = 1; req_addr_i = a1; req_wdata_i = d1;
    while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_addr_i = a2; req_wdata_i = d2;
    for (int c = 1; c <= 8; c++) begin
      if (req_ready_o !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin fails++; $display("FAIL b2b_ready_low: %0d busy cycles with ready high, required 0", bad); end
    checks++;
    if (resp_valid_o !== 1'b1 || req_ready_o !== 1'b1) begin fails++; $display("FAIL b2b_first_idle: resp=%b ready=%b required 1 1", resp_valid_o, req_ready_o); end
    @(negedge clk);
    req_valid_i = 0;
    checks++;
    if (busy_o !== 1'b1 || debugPRFWrEn_o !== 1'b1 || debugPRFAddr_o !== {a2, BO'(0)} || debugPRFWrData_o !== d2[SW-1:0]) begin
      fails++; $display("FAIL b2b_second_start: busy=%b wren=%b addr=%h data=%h required 1 1 %h %h",
                        busy_o, debugPRFWrEn_o, debugPRFAddr_o, debugPRFWrData_o, {a2, BO'(0)}, d2[SW-1:0]);
    end
    while (!resp_valid_o && lat < 40) begin @(negedge clk); lat++; end
    bad = 0;
    for (int k = 0; k < NB; k++) begin
      if (mem[{a1, BO'(k)}] !== d1[k*SW +: SW]) bad++;
      if (mem[{a2, BO'(k)}] !== d2[k*SW +: SW]) bad++;
    end
    checks++;
    if (lat >= 40 || bad != 0) begin fails++; $display("FAIL b2b_contents: %0d wrong bytes, wait %0d, required 0 and <40", bad, lat); end
  endtask

  task automatic test_reset_drain();
    int n = 0, r0;
    @(negedge clk);
    r0 = respCount;
    req_valid_i = 1; req_we_i = 0; req_addr_i = PL'($urandom);
    while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid_i = 0;
    repeat (8) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || resp_valid_o !== 1'b0) begin fails++; $display("FAIL drain_reached: busy=%b resp=%b required 1 0", busy_o, resp_valid_o); end
    reset = 0;
    #1;
    checks++;
    if ({req_ready_o, resp_valid_o, debugPRFWrEn_o, debugPRFAddr_o, debugPRFWrData_o, resp_rdata_o} !== '0 || busy_o !== BUSY_RST) begin
      fails++; $display("FAIL drain_async_reset: ready=%b resp=%b wren=%b addr=%h rdata=%h busy=%b required all 0, busy %b",
                        req_ready_o, resp_valid_o, debugPRFWrEn_o, debugPRFAddr_o, resp_rdata_o, busy_o, BUSY_RST);
    end
    @(negedge clk);
    reset = 1;
    expRdata = '0;
    n = 0;
    while (!req_ready_o && n < 1200) begin @(negedge clk); n++; end
    repeat (12) @(negedge clk);
    checks++;
    if (respCount != r0 || req_ready_o !== 1'b1) begin fails++; $display("FAIL drain_no_resp: pulses=%0d ready=%b required 0 1", respCount - r0, req_ready_o); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = SW'($urandom);
    test_reset();
    test_write_basic();
    test_read_basic();
    test_random();
    test_abort();
    test_back_to_back();
    test_reset_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
